// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side port: the UART consumer (master) strobes re and samples dout/empty;
// the FIFO (slave) drives dout one cycle after re and reports empty.
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  re;
    logic [DATA_WIDTH-1:0] dout;
    logic                  empty;

    modport master (output re, input dout, input empty);
    modport slave  (input re, output dout, output empty);
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: fetches one word per frame and sends
// start, LSB-first data, optional parity and 1-2 stop bits on tx.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           frame_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] PARITY = 3'd4;
    localparam logic [2:0] STOP   = 3'd5;

    logic [2:0]            state;
    logic [CW-1:0]         bit_cnt;
    logic [IW-1:0]         data_idx;
    logic                  stop_idx;
    logic [DATA_WIDTH-1:0] shift_p0;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic                  parity_p0;
    logic                  bit_end;

    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d);
        return (PARITY_ODD != 0) ? ~^d : ^d;
    endfunction

    assign bit_end   = (bit_cnt == CNT_LAST);
    assign shift_nxt = shift_p0 >> 1;

    // Gated by rst_n so no read strobe escapes while the block is held in reset.
    assign fifo.re = rst_n & (state == IDLE) & en & ~fifo.empty;
    assign busy    = (state != IDLE) | fifo.re;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            data_idx   <= '0;
            stop_idx   <= 1'b0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state inside {START, DATA, PARITY, STOP})
                bit_cnt <= bit_end ? '0 : bit_cnt + CW'(1);

            case (state)
                IDLE: begin
                    if (fifo.re)
                        state <= LOAD;
                end
                LOAD: begin
                    tx      <= 1'b0;
                    bit_cnt <= '0;
                    state   <= START;
                end
                START: begin
                    if (bit_end) begin
                        data_idx <= '0;
                        tx       <= shift_p0[0];
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (data_idx == IDX_LAST) begin
                            stop_idx <= 1'b0;
                            if (PARITY_EN != 0) begin
                                tx    <= parity_p0;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            data_idx <= data_idx + IW'(1);
                            tx       <= shift_nxt[0];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop_idx == STOP_LAST) begin
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word capture stage: dout is only looked at during LOAD.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            shift_p0  <= fifo.dout;
            parity_p0 <= parity_bit(fifo.dout);
        end else if (state == DATA && bit_end) begin
            shift_p0  <= shift_nxt;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (plain, even parity + 2 stop, odd parity)
// fed from queued FIFO models; tx traces are compared with a bit-level frame model.
module tb_fifo_uart_tx;
    localparam int CPB  = 4;
    localparam int MAXC = 8192;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    always #5 clk = ~clk;

    fifo_uart_tx_if #(.DATA_WIDTH(8)) fa ();
    fifo_uart_tx_if #(.DATA_WIDTH(8)) fp ();
    fifo_uart_tx_if #(.DATA_WIDTH(8)) fo ();
    logic tx_a, busy_a, fd_a, tx_p, busy_p, fd_p, tx_o, busy_o, fd_o;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo(fa), .tx(tx_a), .busy(busy_a), .frame_done(fd_a));
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo(fp), .tx(tx_p), .busy(busy_p), .frame_done(fd_p));
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_o (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo(fo), .tx(tx_o), .busy(busy_o), .frame_done(fd_o));

    logic [7:0] mem_a [256];
    logic [7:0] mem_p [256];
    logic [7:0] mem_o [256];
    logic [7:0] wr_a = 8'd0, wr_p = 8'd0, wr_o = 8'd0;
    logic [7:0] rd_a = 8'd0, rd_p = 8'd0, rd_o = 8'd0;
    assign fa.empty = (rd_a == wr_a);
    assign fp.empty = (rd_p == wr_p);
    assign fo.empty = (rd_o == wr_o);

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    logic [3:0] log_a [MAXC];
    logic [3:0] log_p [MAXC];
    logic [3:0] log_o [MAXC];

    // FIFO models: data valid the cycle after re, random junk otherwise.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fa.re) begin fa.dout <= mem_a[rd_a]; rd_a <= rd_a + 8'd1; end
        else fa.dout <= 8'($urandom);
        if (fp.re) begin fp.dout <= mem_p[rd_p]; rd_p <= rd_p + 8'd1; end
        else fp.dout <= 8'($urandom);
        if (fo.re) begin fo.dout <= mem_o[rd_o]; rd_o <= rd_o + 8'd1; end
        else fo.dout <= 8'($urandom);
    end

    // Per-cycle trace {frame_done, busy, re, tx}, sampled mid-cycle.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            log_a[13'(cyc)] <= {fd_a, busy_a, fa.re, tx_a};
            log_p[13'(cyc)] <= {fd_p, busy_p, fp.re, tx_p};
            log_o[13'(cyc)] <= {fd_o, busy_o, fo.re, tx_o};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    function automatic logic lg(input int d, input int c, input int b);
        if (c < 0 || c >= MAXC) return 1'bx;
        case (d)
            0:       return log_a[13'(c)][2'(b)];
            1:       return log_p[13'(c)][2'(b)];
            default: return log_o[13'(c)][2'(b)];
        endcase
    endfunction

    function automatic int cnt(input int d, input int b, input int from, input int to);
        int n = 0;
        for (int c = from; c <= to; c++) if (lg(d, c, b) === 1'b1) n++;
        return n;
    endfunction

    function automatic int flen(input int pe, input int sb);
        return (1 + 8 + pe + sb) * CPB;
    endfunction

    // Expected tx at cycle k of a frame (k=0 is the first start-bit cycle).
    function automatic logic exp_tx(input logic [7:0] w, input int pe, input int po, input int k);
        int b = k / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return w[3'(b - 1)];
        if (b == 9 && pe != 0) return 1'((($countones(w) + po) % 2));
        return 1'b1;
    endfunction

    task automatic push(input int d, input logic [7:0] w);
        case (d)
            0:       begin mem_a[wr_a] = w; wr_a = wr_a + 8'd1; end
            1:       begin mem_p[wr_p] = w; wr_p = wr_p + 8'd1; end
            default: begin mem_o[wr_o] = w; wr_o = wr_o + 8'd1; end
        endcase
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    task automatic find_re(input int d, input int from, input int budget, output int at);
        int c = from;
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            @(negedge clk); #1;
            while (c <= cyc && at < 0) begin
                if (lg(d, c, 1) === 1'b1) at = c;
                c++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (tx_a !== 1'b1)   begin bad++; $display("FAIL reset_tx got=%b want=1", tx_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_a); end
        total++; if (fa.re !== 1'b0)  begin bad++; $display("FAIL reset_re got=%b want=0", fa.re); end
        total++; if (fd_a !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b want=0", fd_a); end
        total++; if (tx_p !== 1'b1)   begin bad++; $display("FAIL reset_tx_p got=%b want=1", tx_p); end
        total++; if (tx_o !== 1'b1)   begin bad++; $display("FAIL reset_tx_o got=%b want=1", tx_o); end
        rst_n = 1'b1; en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        int n;
        int fl = flen(0, 1);
        en = 1'b1;
        push(0, 8'hA5);
        find_re(0, cyc, 20, n);
        total++; if (n < 0) begin bad++; $display("FAIL single_re timeout got=none want=pulse"); return; end
        wait_until(n + fl + 5);
        total++; if (cnt(0, 1, n, n + fl + 3) !== 1) begin bad++; $display("FAIL single_re_count got=%0d want=1", cnt(0, 1, n, n + fl + 3)); end
        total++; if (lg(0, n + 1, 0) !== 1'b1) begin bad++; $display("FAIL single_load_tx got=%b want=1", lg(0, n + 1, 0)); end
        for (int k = 0; k < fl; k++) begin
            total++;
            if (lg(0, n + 2 + k, 0) !== exp_tx(8'hA5, 0, 0, k)) begin
                bad++; $display("FAIL single_tx k=%0d got=%b want=%b", k, lg(0, n + 2 + k, 0), exp_tx(8'hA5, 0, 0, k));
            end
        end
        total++; if (lg(0, n + 2 + fl, 3) !== 1'b1) begin bad++; $display("FAIL single_done_time got=%b want=1", lg(0, n + 2 + fl, 3)); end
        total++; if (cnt(0, 3, n, n + fl + 3) !== 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", cnt(0, 3, n, n + fl + 3)); end
        total++; if (lg(0, n, 2) !== 1'b1) begin bad++; $display("FAIL single_busy_start got=%b want=1", lg(0, n, 2)); end
        total++; if (lg(0, n + 1 + fl, 2) !== 1'b1) begin bad++; $display("FAIL single_busy_end got=%b want=1", lg(0, n + 1 + fl, 2)); end
        total++; if (lg(0, n + 2 + fl, 2) !== 1'b0) begin bad++; $display("FAIL single_busy_clear got=%b want=0", lg(0, n + 2 + fl, 2)); end
    endtask

    task automatic test_empty;
        int t0 = cyc;
        en = 1'b1;
        wait_until(t0 + 201);
        total++; if (cnt(0, 1, t0, t0 + 199) !== 0) begin bad++; $display("FAIL empty_re got=%0d want=0", cnt(0, 1, t0, t0 + 199)); end
        total++; if (cnt(0, 0, t0, t0 + 199) !== 200) begin bad++; $display("FAIL empty_tx_high got=%0d want=200", cnt(0, 0, t0, t0 + 199)); end
        total++; if (cnt(0, 2, t0, t0 + 199) !== 0) begin bad++; $display("FAIL empty_busy got=%0d want=0", cnt(0, 2, t0, t0 + 199)); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w [6];
        int re_q[$];
        int t0;
        int fl = flen(0, 1);
        w[0] = 8'h00; w[1] = 8'hFF; w[2] = 8'h3C;
        for (int i = 3; i < 6; i++) w[i] = 8'($urandom);
        en = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 6; i++) push(0, w[i]);
        wait_until(t0 + 6 * (fl + 2) + 20);
        for (int c = t0; c < cyc; c++) if (lg(0, c, 1) === 1'b1) re_q.push_back(c);
        total++; if (re_q.size() !== 6) begin bad++; $display("FAIL b2b_re_count got=%0d want=6", re_q.size()); end
        total++; if (cnt(0, 3, t0, cyc - 1) !== 6) begin bad++; $display("FAIL b2b_done_count got=%0d want=6", cnt(0, 3, t0, cyc - 1)); end
        for (int i = 0; i < re_q.size() && i < 6; i++) begin
            for (int k = 0; k < fl; k++) begin
                total++;
                if (lg(0, re_q[i] + 2 + k, 0) !== exp_tx(w[i], 0, 0, k)) begin
                    bad++; $display("FAIL b2b_tx frame=%0d k=%0d got=%b want=%b", i, k, lg(0, re_q[i] + 2 + k, 0), exp_tx(w[i], 0, 0, k));
                end
            end
            if (i > 0) begin
                total++;
                if ((re_q[i] + 2) - (re_q[i-1] + 2 + fl) !== 2) begin
                    bad++; $display("FAIL b2b_gap frame=%0d got=%0d want=2", i, (re_q[i] + 2) - (re_q[i-1] + 2 + fl));
                end
            end
        end
    endtask

    task automatic test_parity;
        logic [7:0] w2 [3];
        int t0;
        w2[1] = 8'($urandom);
        w2[2] = 8'($urandom);
        en = 1'b1;
        t0 = cyc;
        push(1, 8'h01); push(1, w2[1]);
        push(2, 8'h01); push(2, w2[2]);
        wait_until(t0 + 2 * (flen(1, 2) + 2) + 20);
        for (int d = 1; d <= 2; d++) begin
            int re_q[$];
            int po = d - 1;
            int fl = flen(1, (d == 1) ? 2 : 1);
            for (int c = t0; c < cyc; c++) if (lg(d, c, 1) === 1'b1) re_q.push_back(c);
            total++; if (re_q.size() !== 2) begin bad++; $display("FAIL par_re_count dut=%0d got=%0d want=2", d, re_q.size()); end
            if (re_q.size() >= 1) begin
                total++;
                if (lg(d, re_q[0] + 2 + 9 * CPB + 1, 0) !== ((d == 1) ? 1'b1 : 1'b0)) begin
                    bad++; $display("FAIL par_bit_01 dut=%0d got=%b want=%b", d, lg(d, re_q[0] + 2 + 9 * CPB + 1, 0), (d == 1) ? 1'b1 : 1'b0);
                end
                total++;
                if (lg(d, re_q[0] + 2 + fl, 3) !== 1'b1) begin
                    bad++; $display("FAIL par_done dut=%0d got=%b want=1", d, lg(d, re_q[0] + 2 + fl, 3));
                end
            end
            if (re_q.size() >= 2) begin
                total++;
                if (re_q[1] - re_q[0] !== fl + 2) begin
                    bad++; $display("FAIL par_spacing dut=%0d got=%0d want=%0d", d, re_q[1] - re_q[0], fl + 2);
                end
            end
            for (int i = 0; i < re_q.size() && i < 2; i++) begin
                logic [7:0] wv = (i == 0) ? 8'h01 : w2[d];
                for (int k = 0; k < fl; k++) begin
                    total++;
                    if (lg(d, re_q[i] + 2 + k, 0) !== exp_tx(wv, 1, po, k)) begin
                        bad++; $display("FAIL par_tx dut=%0d frame=%0d k=%0d got=%b want=%b", d, i, k, lg(d, re_q[i] + 2 + k, 0), exp_tx(wv, 1, po, k));
                    end
                end
            end
        end
    endtask

    task automatic test_en_drop;
        logic [7:0] w0 = 8'($urandom);
        logic [7:0] w1 = 8'($urandom);
        int n, m, t1;
        int fl = flen(0, 1);
        en = 1'b1;
        push(0, w0); push(0, w1);
        find_re(0, cyc, 20, n);
        total++; if (n < 0) begin bad++; $display("FAIL endrop_re timeout got=none want=pulse"); return; end
        wait_until(n + 2 + 4 * CPB + 1);
        en = 1'b0;
        wait_until(n + fl + 40);
        t1 = cyc;
        for (int k = 0; k < fl; k++) begin
            total++;
            if (lg(0, n + 2 + k, 0) !== exp_tx(w0, 0, 0, k)) begin
                bad++; $display("FAIL endrop_tx k=%0d got=%b want=%b", k, lg(0, n + 2 + k, 0), exp_tx(w0, 0, 0, k));
            end
        end
        total++; if (lg(0, n + 2 + fl, 3) !== 1'b1) begin bad++; $display("FAIL endrop_done got=%b want=1", lg(0, n + 2 + fl, 3)); end
        total++; if (cnt(0, 1, n + 1, t1 - 1) !== 0) begin bad++; $display("FAIL endrop_no_re got=%0d want=0", cnt(0, 1, n + 1, t1 - 1)); end
        en = 1'b1;
        find_re(0, t1, 10, m);
        total++; if (m !== t1) begin bad++; $display("FAIL endrop_resume got=%0d want=%0d", m, t1); end
        if (m < 0) return;
        wait_until(m + fl + 4);
        for (int k = 0; k < fl; k++) begin
            total++;
            if (lg(0, m + 2 + k, 0) !== exp_tx(w1, 0, 0, k)) begin
                bad++; $display("FAIL endrop_tx2 k=%0d got=%b want=%b", k, lg(0, m + 2 + k, 0), exp_tx(w1, 0, 0, k));
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] w0 = 8'($urandom);
        logic [7:0] w1 = 8'($urandom);
        int n, m;
        int fl = flen(0, 1);
        en = 1'b1;
        push(0, w0); push(0, w1);
        find_re(0, cyc, 20, n);
        total++; if (n < 0) begin bad++; $display("FAIL rstmid_re timeout got=none want=pulse"); return; end
        wait_until(n + 2 + 3 * CPB + 1);
        rst_n = 1'b0;
        #1;
        total++; if (tx_a !== 1'b1)   begin bad++; $display("FAIL rstmid_tx got=%b want=1", tx_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy_a); end
        total++; if (fa.re !== 1'b0)  begin bad++; $display("FAIL rstmid_re got=%b want=0", fa.re); end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        find_re(0, cyc, 10, m);
        total++; if (m < 0) begin bad++; $display("FAIL rstmid_refetch timeout got=none want=pulse"); return; end
        wait_until(m + fl + 10);
        for (int k = 0; k < fl; k++) begin
            total++;
            if (lg(0, m + 2 + k, 0) !== exp_tx(w1, 0, 0, k)) begin
                bad++; $display("FAIL rstmid_tx k=%0d got=%b want=%b", k, lg(0, m + 2 + k, 0), exp_tx(w1, 0, 0, k));
            end
        end
        total++; if (cnt(0, 1, m, cyc - 1) !== 1) begin bad++; $display("FAIL rstmid_reads got=%0d want=1", cnt(0, 1, m, cyc - 1)); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_empty();
        test_back_to_back();
        test_parity();
        test_en_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
